// File: rtl/double_frame_buffer_pkg.sv
// Shared types and address helpers for the double-buffered frame store.
package fb_pkg;

   typedef enum logic [1:0] {IDLE, CLEAR, SWAP_WAIT} fb_state_e;

   localparam int PIX_CHAN_W = 8;

   typedef struct packed {
      logic [PIX_CHAN_W-1:0] r;
      logic [PIX_CHAN_W-1:0] g;
      logic [PIX_CHAN_W-1:0] b;
   } pixel_t;

   function automatic int unsigned fb_depth(input int unsigned h_res, input int unsigned v_res);
      return h_res * v_res;
   endfunction

   function automatic int unsigned fb_addr_w(input int unsigned h_res, input int unsigned v_res);
      return $clog2(h_res * v_res);
   endfunction

   function automatic int unsigned fb_addr(input int unsigned x, input int unsigned y,
                                           input int unsigned h_res);
      return y * h_res + x;
   endfunction

endpackage

// File: rtl/double_frame_buffer_if.sv
// Pixel write port between the drawing logic (master) and the frame buffer (slave).
interface fb_wr_if #(
   parameter int X_W   = 10,
   parameter int Y_W   = 10,
   parameter int PIX_W = 24
);
   logic             wr_valid;
   logic             wr_ready;
   logic [X_W-1:0]   wr_x;
   logic [Y_W-1:0]   wr_y;
   logic [PIX_W-1:0] wr_color;

   modport master (output wr_valid, output wr_x, output wr_y, output wr_color, input wr_ready);
   modport slave  (input wr_valid, input wr_x, input wr_y, input wr_color, output wr_ready);
endinterface

// File: rtl/double_frame_buffer_fb_bank_ram.sv
// One frame bank: simple dual-port RAM with a registered read port, contents never reset.
module fb_bank_ram #(
   parameter int DEPTH  = 307200,
   parameter int DATA_W = 24,
   parameter int ADDR_W = 19
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end
endmodule

// File: rtl/double_frame_buffer.sv
// Double-buffered pixel store: writes/clears hit the back bank, scan-out reads the front
// bank with 2-cycle latency, and banks exchange only on frame_start.
module double_frame_buffer
   import fb_pkg::*;
#(
   parameter int H_RES  = 640,
   parameter int V_RES  = 480,
   parameter int CHAN_W = 8,
   parameter int X_W    = 10,
   parameter int Y_W    = 10
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clear,
   input  logic [3*CHAN_W-1:0] clear_color,
   input  logic                swap,
   input  logic                frame_start,
   fb_wr_if.slave              wr,
   input  logic                draw,
   input  logic [X_W-1:0]      position_x,
   input  logic [Y_W-1:0]      position_y,
   output logic [CHAN_W-1:0]   output_r,
   output logic [CHAN_W-1:0]   output_g,
   output logic [CHAN_W-1:0]   output_b,
   output logic                busy,
   output logic                swap_done,
   output logic                front_sel
);
   localparam int PIX_W  = 3 * CHAN_W;
   localparam int DEPTH  = int'(fb_depth(H_RES, V_RES));
   localparam int ADDR_W = int'(fb_addr_w(H_RES, V_RES));

   fb_state_e         state;
   logic              pending;
   logic [ADDR_W-1:0] clr_cnt;
   logic [PIX_W-1:0]  clr_color;

   logic              wr_in_range;
   logic [ADDR_W-1:0] wr_addr;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_waddr;
   logic [PIX_W-1:0]  ram_wdata;

   assign wr_in_range = (32'(wr.wr_x) < 32'(H_RES)) && (32'(wr.wr_y) < 32'(V_RES));
   assign wr_addr     = ADDR_W'(fb_addr(32'(wr.wr_x), 32'(wr.wr_y), H_RES));
   assign wr.wr_ready = (state == IDLE) && !rst;
   assign busy        = (state != IDLE) || pending;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         front_sel <= 1'b0;
         pending   <= 1'b0;
         swap_done <= 1'b0;
         clr_cnt   <= '0;
      end else begin
         swap_done <= 1'b0;
         case (state)
            IDLE: begin
               if (clear) begin
                  state     <= CLEAR;
                  clr_color <= clear_color;
                  clr_cnt   <= '0;
                  pending   <= swap;
               end else if (swap) begin
                  state <= SWAP_WAIT;
               end
            end
            CLEAR: begin
               clr_cnt <= clr_cnt + 1'b1;
               if (swap) pending <= 1'b1;
               if (clr_cnt == ADDR_W'(DEPTH - 1))
                  state <= (pending || swap) ? SWAP_WAIT : IDLE;
            end
            SWAP_WAIT: begin
               if (frame_start) begin
                  front_sel <= ~front_sel;
                  swap_done <= 1'b1;
                  pending   <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Reset gates the write so an aborted clear leaves the current pixel untouched.
   always_comb begin
      ram_we    = 1'b0;
      ram_waddr = clr_cnt;
      ram_wdata = clr_color;
      if (!rst) begin
         if (state == CLEAR) begin
            ram_we = 1'b1;
         end else if (state == IDLE && wr.wr_valid && wr_in_range) begin
            ram_we    = 1'b1;
            ram_waddr = wr_addr;
            ram_wdata = wr.wr_color;
         end
      end
   end

   logic              rd_in_range;
   logic [ADDR_W-1:0] raddr_p1;
   logic              vld_p1, sel_p1;
   logic              vld_p2, sel_p2;
   logic [PIX_W-1:0]  rdata0_p2, rdata1_p2, pix_p2;

   assign rd_in_range = (32'(position_x) < 32'(H_RES)) && (32'(position_y) < 32'(V_RES));

   // Stage p1: registered address, draw qualifier and bank select
   always_ff @(posedge clk) begin
      raddr_p1 <= rd_in_range ? ADDR_W'(fb_addr(32'(position_x), 32'(position_y), H_RES)) : '0;
      sel_p1   <= front_sel;
      sel_p2   <= sel_p1;
      if (rst) begin
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
      end else begin
         vld_p1 <= draw && rd_in_range;
         vld_p2 <= vld_p1;
      end
   end

   fb_bank_ram #(.DEPTH(DEPTH), .DATA_W(PIX_W), .ADDR_W(ADDR_W)) u_bank0 (
      .clk   (clk),
      .we    (ram_we && front_sel),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .raddr (raddr_p1),
      .rdata (rdata0_p2)
   );

   fb_bank_ram #(.DEPTH(DEPTH), .DATA_W(PIX_W), .ADDR_W(ADDR_W)) u_bank1 (
      .clk   (clk),
      .we    (ram_we && !front_sel),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .raddr (raddr_p1),
      .rdata (rdata1_p2)
   );

   // Stage p2: bank data selected by the front_sel captured with the request
   assign pix_p2   = vld_p2 ? (sel_p2 ? rdata1_p2 : rdata0_p2) : '0;
   assign output_r = pix_p2[3*CHAN_W-1:2*CHAN_W];
   assign output_g = pix_p2[2*CHAN_W-1:CHAN_W];
   assign output_b = pix_p2[CHAN_W-1:0];

endmodule

// File: tb/tb_double_frame_buffer.sv
// Directed bench for double_frame_buffer on an 8x4 frame with 8-bit channels.
module tb_double_frame_buffer;
   localparam int H_RES  = 8;
   localparam int V_RES  = 4;
   localparam int CHAN_W = 8;
   localparam int X_W    = 10;
   localparam int Y_W    = 10;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              clear = 1'b0;
   logic [23:0]       clear_color = '0;
   logic              swap = 1'b0;
   logic              frame_start = 1'b0;
   logic              draw = 1'b0;
   logic [X_W-1:0]    position_x = '0;
   logic [Y_W-1:0]    position_y = '0;
   logic [CHAN_W-1:0] output_r, output_g, output_b;
   logic              busy, swap_done, front_sel;

   int checks = 0;
   int failures = 0;

   fb_wr_if #(.X_W(X_W), .Y_W(Y_W), .PIX_W(24)) wr_bus ();

   double_frame_buffer #(
      .H_RES(H_RES), .V_RES(V_RES), .CHAN_W(CHAN_W), .X_W(X_W), .Y_W(Y_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .clear       (clear),
      .clear_color (clear_color),
      .swap        (swap),
      .frame_start (frame_start),
      .wr          (wr_bus),
      .draw        (draw),
      .position_x  (position_x),
      .position_y  (position_y),
      .output_r    (output_r),
      .output_g    (output_g),
      .output_b    (output_b),
      .busy        (busy),
      .swap_done   (swap_done),
      .front_sel   (front_sel)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic rd(input int x, input int y, input logic d, output logic [23:0] pix);
      position_x = X_W'(x);
      position_y = Y_W'(y);
      draw = d;
      tick();
      draw = 1'b0;
      tick();
      pix = {output_r, output_g, output_b};
   endtask

   task automatic do_swap();
      swap = 1'b1;
      tick();
      swap = 1'b0;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      tick();
   endtask

   logic [23:0] pix;
   int          bad;

   initial begin
      wr_bus.wr_valid = 1'b0;
      wr_bus.wr_x = '0;
      wr_bus.wr_y = '0;
      wr_bus.wr_color = '0;
      tick();
      tick();
      // reset state, sampled while rst is still high
      chk("rst_wr_ready", 32'(wr_bus.wr_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_front_sel", 32'(front_sel), 32'd0);
      chk("rst_swap_done", 32'(swap_done), 32'd0);
      chk("rst_out", {8'd0, output_r, output_g, output_b}, 32'd0);
      rst = 1'b0;
      tick();
      chk("post_rst_wr_ready", 32'(wr_bus.wr_ready), 32'd1);

      // write (3,2) red, swap, frame_start, read back
      wr_bus.wr_valid = 1'b1; wr_bus.wr_x = 10'd3; wr_bus.wr_y = 10'd2;
      wr_bus.wr_color = 24'hFF0000;
      chk("wr_ready_idle", 32'(wr_bus.wr_ready), 32'd1);
      tick();
      wr_bus.wr_valid = 1'b0;
      swap = 1'b1;
      tick();
      swap = 1'b0;
      chk("swap_wait_busy", 32'(busy), 32'd1);
      chk("swap_wait_ready", 32'(wr_bus.wr_ready), 32'd0);
      repeat (6) tick();
      chk("no_fs_front_sel", 32'(front_sel), 32'd0);
      chk("no_fs_ready", 32'(wr_bus.wr_ready), 32'd0);
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      chk("swap_done_pulse", 32'(swap_done), 32'd1);
      chk("front_sel_1", 32'(front_sel), 32'd1);
      chk("busy_after_swap", 32'(busy), 32'd0);
      tick();
      chk("swap_done_one_cycle", 32'(swap_done), 32'd0);
      position_x = 10'd3; position_y = 10'd2; draw = 1'b1;
      tick();
      draw = 1'b0;
      chk("rd_lat1_zero", {8'd0, output_r, output_g, output_b}, 32'd0);
      tick();
      chk("rd_lat2_r", 32'(output_r), 32'hFF);
      chk("rd_lat2_gb", {16'd0, output_g, output_b}, 32'd0);

      // clear back bank (bank0) to green
      clear = 1'b1; clear_color = 24'h00FF00;
      tick();
      clear = 1'b0;
      bad = 0;
      for (int i = 0; i < 32; i++) begin
         if (busy !== 1'b1 || wr_bus.wr_ready !== 1'b0) bad++;
         tick();
      end
      chk("clear_busy_32", 32'(bad), 32'd0);
      chk("clear_done_busy", 32'(busy), 32'd0);
      chk("clear_done_ready", 32'(wr_bus.wr_ready), 32'd1);
      do_swap();
      chk("front_sel_0", 32'(front_sel), 32'd0);
      for (int i = 0; i < 32; i++) begin
         rd(i % H_RES, i / H_RES, 1'b1, pix);
         chk($sformatf("green_px%0d", i), 32'(pix), 32'h00FF00);
      end

      // clear and swap together, extra swap and early frame_start ignored
      clear = 1'b1; swap = 1'b1; clear_color = 24'h0000FF;
      tick();
      clear = 1'b0; swap = 1'b0;
      for (int i = 0; i < 32; i++) begin
         frame_start = (i == 5);
         swap = (i == 9);
         tick();
      end
      frame_start = 1'b0; swap = 1'b0;
      chk("cs_front_unchanged", 32'(front_sel), 32'd0);
      chk("cs_swap_wait_busy", 32'(busy), 32'd1);
      chk("cs_swap_wait_ready", 32'(wr_bus.wr_ready), 32'd0);
      swap = 1'b1;
      tick();
      swap = 1'b0;
      tick();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      chk("cs_swap_done", 32'(swap_done), 32'd1);
      chk("cs_front_sel", 32'(front_sel), 32'd1);
      tick();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      tick();
      chk("cs_single_toggle", 32'(front_sel), 32'd1);
      chk("cs_idle_busy", 32'(busy), 32'd0);
      rd(0, 0, 1'b1, pix);
      chk("blue_px0", 32'(pix), 32'h0000FF);
      rd(3, 2, 1'b1, pix);
      chk("blue_px19", 32'(pix), 32'h0000FF);

      // out-of-range writes dropped, out-of-range and draw=0 reads are zero
      wr_bus.wr_valid = 1'b1; wr_bus.wr_x = 10'd8; wr_bus.wr_y = 10'd0;
      wr_bus.wr_color = 24'hFF0000;
      chk("oor_x_ready", 32'(wr_bus.wr_ready), 32'd1);
      tick();
      wr_bus.wr_x = 10'd0; wr_bus.wr_y = 10'd4;
      chk("oor_y_ready", 32'(wr_bus.wr_ready), 32'd1);
      tick();
      wr_bus.wr_valid = 1'b0;
      do_swap();
      chk("oor_front_sel", 32'(front_sel), 32'd0);
      rd(0, 1, 1'b1, pix);
      chk("oor_px8_green", 32'(pix), 32'h00FF00);
      rd(0, 0, 1'b1, pix);
      chk("oor_px0_green", 32'(pix), 32'h00FF00);
      rd(8, 0, 1'b1, pix);
      chk("oor_read_zero", 32'(pix), 32'd0);
      rd(3, 2, 1'b0, pix);
      chk("draw0_zero", 32'(pix), 32'd0);

      // reset during clear cycle 10 into bank0 while bank1 is front
      do_swap();
      chk("pre_abort_front", 32'(front_sel), 32'd1);
      clear = 1'b1; clear_color = 24'hABCDEF;
      tick();
      clear = 1'b0;
      repeat (10) tick();
      rst = 1'b1;
      tick();
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_front_sel", 32'(front_sel), 32'd0);
      chk("abort_out", {8'd0, output_r, output_g, output_b}, 32'd0);
      rst = 1'b0;
      tick();
      chk("abort_idle_ready", 32'(wr_bus.wr_ready), 32'd1);
      for (int i = 0; i < 32; i++) begin
         rd(i % H_RES, i / H_RES, 1'b1, pix);
         chk($sformatf("abort_px%0d", i), 32'(pix), (i < 10) ? 32'hABCDEF : 32'h00FF00);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end
endmodule
